// File: rtl/flash_sector_mapper.sv
// Logical-to-physical flash sector remap table with per-entry write lock.
// One lookup in flight at a time; the table self-initialises to identity after reset.
module flash_sector_mapper #(
    parameter int SECTOR_W    = 3,
    parameter int NUM_SECTORS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SECTOR_W-1:0] req_sector,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SECTOR_W-1:0] rsp_flash_sector,
    output logic                rsp_err,
    input  logic                cfg_we,
    input  logic [SECTOR_W-1:0] cfg_sector,
    input  logic [SECTOR_W-1:0] cfg_map,
    input  logic                cfg_lock,
    output logic                cfg_err,
    output logic                init_done
);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    localparam logic [SECTOR_W-1:0] LAST_SECTOR = SECTOR_W'(NUM_SECTORS);

    state_t                state_reg;
    logic [SECTOR_W-1:0]   init_ptr_reg;
    logic [SECTOR_W-1:0]   map_reg [1:NUM_SECTORS];
    logic [NUM_SECTORS:1]  lock_reg;

    logic [NUM_SECTORS:1]  init_hit;
    logic [NUM_SECTORS:1]  cfg_hit;
    logic [SECTOR_W-1:0]   lookup_map;
    logic                  req_in_range;
    logic                  cfg_in_range;
    logic                  cfg_locked;
    logic                  cfg_active;
    logic                  cfg_accept;
    logic                  cfg_reject;
    logic                  req_hs;

    // Per-entry write selects for the init sweep and for configuration writes.
    for (genvar gi = 1; gi <= NUM_SECTORS; gi++) begin : g_entry_sel
        assign init_hit[gi] = (state_reg == INIT) && (init_ptr_reg == SECTOR_W'(gi));
        assign cfg_hit[gi]  = cfg_accept && (cfg_sector == SECTOR_W'(gi));
    end

    always_comb begin
        lookup_map = '0;
        cfg_locked = 1'b0;
        for (int i = 1; i <= NUM_SECTORS; i++) begin
            if (req_sector == SECTOR_W'(i)) begin
                lookup_map = map_reg[i];
            end
            if (cfg_sector == SECTOR_W'(i)) begin
                cfg_locked = lock_reg[i];
            end
        end
    end

    assign req_in_range = (req_sector != '0) && (req_sector <= LAST_SECTOR);
    assign cfg_in_range = (cfg_sector != '0) && (cfg_sector <= LAST_SECTOR);
    assign cfg_active   = cfg_we && (state_reg != INIT);
    assign cfg_accept   = cfg_active && cfg_in_range && !cfg_locked;
    assign cfg_reject   = cfg_active && !(cfg_in_range && !cfg_locked);
    assign req_hs       = req_valid && req_ready;

    // Table storage; the lookup in the controller samples the pre-write value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_reg <= '0;
            for (int i = 1; i <= NUM_SECTORS; i++) begin
                map_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= NUM_SECTORS; i++) begin
                if (init_hit[i]) begin
                    map_reg[i]  <= SECTOR_W'(i);
                    lock_reg[i] <= 1'b0;
                end else if (cfg_hit[i]) begin
                    map_reg[i] <= cfg_map;
                    if (cfg_lock) begin
                        lock_reg[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= INIT;
            init_ptr_reg     <= SECTOR_W'(1);
            req_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_flash_sector <= '0;
            rsp_err          <= 1'b0;
            cfg_err          <= 1'b0;
            init_done        <= 1'b0;
        end else begin
            cfg_err <= cfg_reject;
            case (state_reg)
                INIT: begin
                    if (init_ptr_reg == LAST_SECTOR) begin
                        state_reg <= IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        init_ptr_reg <= init_ptr_reg + SECTOR_W'(1);
                    end
                end
                IDLE: begin
                    if (req_hs) begin
                        state_reg        <= RESP;
                        req_ready        <= 1'b0;
                        rsp_valid        <= 1'b1;
                        rsp_flash_sector <= req_in_range ? lookup_map : '0;
                        rsp_err          <= !req_in_range;
                    end
                end
                RESP: begin
                    // Response fields hold until the consumer takes them.
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sector_mapper.sv
// Randomised and directed checks of flash_sector_mapper against a table-level model.
module tb_flash_sector_mapper;
    localparam int SW = 3;
    localparam int N  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_sector = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [SW-1:0] rsp_flash_sector;
    logic          rsp_err;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_sector = '0;
    logic [SW-1:0] cfg_map = '0;
    logic          cfg_lock = 1'b0;
    logic          cfg_err;
    logic          init_done;

    // Second instance with a wider table.
    logic          b_reset = 1'b1;
    logic          b_req_valid = 1'b0;
    logic          b_req_ready;
    logic [3:0]    b_req_sector = '0;
    logic          b_rsp_valid;
    logic          b_rsp_ready = 1'b0;
    logic [3:0]    b_rsp_flash_sector;
    logic          b_rsp_err;
    logic          b_cfg_err;
    logic          b_init_done;

    always #5 clk = ~clk;

    flash_sector_mapper #(.SECTOR_W(SW), .NUM_SECTORS(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_sector(req_sector),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_flash_sector(rsp_flash_sector), .rsp_err(rsp_err),
        .cfg_we(cfg_we), .cfg_sector(cfg_sector), .cfg_map(cfg_map),
        .cfg_lock(cfg_lock), .cfg_err(cfg_err), .init_done(init_done)
    );

    flash_sector_mapper #(.SECTOR_W(4), .NUM_SECTORS(12)) dut_b (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sector(b_req_sector),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_flash_sector(b_rsp_flash_sector), .rsp_err(b_rsp_err),
        .cfg_we(1'b0), .cfg_sector(4'd0), .cfg_map(4'd0),
        .cfg_lock(1'b0), .cfg_err(b_cfg_err), .init_done(b_init_done)
    );

    int errors = 0;
    int checks = 0;

    // Model state: remap table, locks, cycles of init remaining, and one pending response.
    int  tbl [16];
    bit  lk [16];
    int  init_left;
    bit  pending;
    int  m_flash;
    bit  m_err;
    bit  m_cfg_err;
    bit  model_on = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            tbl[i] = i;
            lk[i]  = 1'b0;
        end
        init_left = N;
        pending   = 1'b0;
        m_flash   = 0;
        m_err     = 1'b0;
        m_cfg_err = 1'b0;
    endtask

    // Applies inputs for one cycle, advances the model across the edge, returns at next negedge.
    task automatic drive(input bit rv, input int rs, input bit rr,
                         input bit we, input int cs, input int cm, input bit cl);
        bool_step : begin
            req_valid  = rv;
            req_sector = SW'(rs);
            rsp_ready  = rr;
            cfg_we     = we;
            cfg_sector = SW'(cs);
            cfg_map    = SW'(cm);
            cfg_lock   = cl;
            m_cfg_err  = 1'b0;
            if (init_left > 0) begin
                init_left--;
            end else begin
                if (pending) begin
                    if (rr) pending = 1'b0;
                end else if (rv) begin
                    pending = 1'b1;
                    m_err   = (rs < 1 || rs > N);
                    m_flash = m_err ? 0 : tbl[rs];
                end
                if (we) begin
                    if (cs < 1 || cs > N || lk[cs]) begin
                        m_cfg_err = 1'b1;
                    end else begin
                        tbl[cs] = cm;
                        if (cl) lk[cs] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        cfg_we    = 1'b0;
        model_reset();
        #1;
        check({tag, "_rsp_valid_async"}, 32'(rsp_valid), 0);
        check({tag, "_req_ready_async"}, 32'(req_ready), 0);
        check({tag, "_init_done_async"}, 32'(init_done), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lookup(input int s, input int exp_map, input bit exp_err, input string tag);
        drive(1, s, 0, 0, 0, 0, 0);
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_sector"}, 32'(rsp_flash_sector), 32'(exp_map));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        drive(0, 0, 1, 0, 0, 0, 0);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (model_on) begin
            check("cmp_init_done", 32'(init_done), 32'(init_left == 0));
            check("cmp_req_ready", 32'(req_ready), 32'(init_left == 0 && !pending));
            check("cmp_rsp_valid", 32'(rsp_valid), 32'(pending));
            check("cmp_cfg_err", 32'(cfg_err), 32'(m_cfg_err));
            if (pending) begin
                check("cmp_rsp_sector", 32'(rsp_flash_sector), 32'(m_flash));
                check("cmp_rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sector", 32'(rsp_flash_sector), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_init_done", 32'(init_done), 0);
        reset = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            idle();
            if (i == 4) check("init_done_after4", 32'(init_done), 0);
            if (i == 5) check("init_done_after5", 32'(init_done), 1);
        end
        for (int s = 1; s <= 5; s++) lookup(s, s, 0, "ident");
        lookup(0, 0, 1, "range0");
        lookup(6, 0, 1, "range6");
        lookup(7, 0, 1, "range7");

        // Locked entry rejects a later write.
        drive(0, 0, 0, 1, 2, 6, 1);
        check("lock_wr_cfg_err", 32'(cfg_err), 0);
        drive(0, 0, 0, 1, 2, 3, 0);
        check("locked_wr_cfg_err", 32'(cfg_err), 1);
        idle();
        check("cfg_err_pulse_end", 32'(cfg_err), 0);
        lookup(2, 6, 0, "locked2");

        // Back-pressured response holds.
        drive(1, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_sector", 32'(rsp_flash_sector), 4);
            check("hold_req_ready", 32'(req_ready), 0);
            drive(0, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        check("release_req_ready", 32'(req_ready), 1);
        check("release_rsp_valid", 32'(rsp_valid), 0);

        // Same-cycle lookup and remap of sector 3.
        drive(1, 3, 0, 1, 3, 7, 0);
        check("same_cycle_sector", 32'(rsp_flash_sector), 3);
        drive(0, 0, 1, 0, 0, 0, 0);
        lookup(3, 7, 0, "after_remap3");

        // Reset while a response is pending.
        drive(1, 2, 0, 0, 0, 0, 0);
        check("pre_reset_valid", 32'(rsp_valid), 1);
        do_reset("mid_resp");
        for (int i = 0; i < 5; i++) idle();
        lookup(2, 2, 0, "post_reset2");
        lookup(3, 3, 0, "post_reset3");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rand");
            end else begin
                drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 9) == 0);
            end
        end

        // Wider instance: 12-entry init and range boundary.
        model_on = 1'b0;
        b_reset = 1'b0;
        n = 0;
        while (!b_init_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w_init_cycles", 32'(n), 12);
        b_req_valid = 1'b1;
        b_req_sector = 4'd12;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("w_lookup12_valid", 32'(b_rsp_valid), 1);
        check("w_lookup12_sector", 32'(b_rsp_flash_sector), 12);
        check("w_lookup12_err", 32'(b_rsp_err), 0);
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        b_req_sector = 4'd13;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("w_lookup13_valid", 32'(b_rsp_valid), 1);
        check("w_lookup13_sector", 32'(b_rsp_flash_sector), 0);
        check("w_lookup13_err", 32'(b_rsp_err), 1);
        check("w_cfg_err", 32'(b_cfg_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
